// File: rtl/gain_div.sv
// gain_div: streaming signed divide of each sample by (gain << 4), rounded toward zero,
// using a one-bit-per-cycle restoring divider between two FWFT FIFOs.
module gain_div #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [31:0]           gain,
   input  logic [DATA_WIDTH-1:0] in_dout,
   input  logic                  in_empty,
   output logic                  in_rd_en,
   output logic [DATA_WIDTH-1:0] out_din,
   input  logic                  out_full,
   output logic                  out_wr_en
);
   typedef enum logic [1:0] {S_IDLE, S_DIV, S_OUT} state_t;
   state_t state, state_nx;
   logic [DATA_WIDTH-1:0] mag, quo, quo_nx;
   logic [35:0] divisor;
   logic [36:0] rem, rem_sh;
   logic [5:0] cnt;
   logic neg, fit, last;

   always_ff @(posedge clock or posedge reset)
      if (reset) state <= S_IDLE;
      else state <= state_nx;

   always_comb begin
      last = cnt == 6'(DATA_WIDTH - 1);
      state_nx = (state == S_IDLE && in_rd_en) ? (gain == '0 ? S_OUT : S_DIV) :
                 (state == S_DIV && last)      ? S_OUT :
                 (state == S_OUT && out_wr_en) ? S_IDLE : state;
   end

   always_comb begin
      in_rd_en  = !reset && state == S_IDLE && !in_empty;
      out_wr_en = !reset && state == S_OUT && !out_full;
   end

   // mag is consumed MSB-first as a shift register feeding the remainder
   always_comb begin
      rem_sh = {rem[35:0], mag[DATA_WIDTH-1]};
      fit    = rem_sh >= {1'b0, divisor};
      quo_nx = {quo[DATA_WIDTH-2:0], fit};
   end

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         mag     <= '0;
         neg     <= 1'b0;
         divisor <= '0;
         rem     <= '0;
         quo     <= '0;
         cnt     <= '0;
         out_din <= '0;
      end else if (in_rd_en) begin
         mag     <= in_dout[DATA_WIDTH-1] ? -in_dout : in_dout;
         neg     <= in_dout[DATA_WIDTH-1];
         divisor <= {gain, 4'b0};
         rem     <= '0;
         quo     <= '0;
         cnt     <= '0;
         if (gain == '0)
            out_din <= in_dout[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (state == S_DIV) begin
         mag <= mag << 1;
         rem <= fit ? rem_sh - {1'b0, divisor} : rem_sh;
         quo <= quo_nx;
         cnt <= cnt + 6'd1;
         if (last) out_din <= neg ? -quo_nx : quo_nx;
      end
endmodule

// File: tb/tb_gain_div.sv
// tb_gain_div: directed vector table, back-pressure and reset sequences, and a random
// FIFO-driven stream checked against an arithmetic reference model.
module tb_gain_div;
   logic clock = 0, reset = 1;
   logic [31:0] gain = 0, in_dout = 0, out_din;
   logic in_empty = 1, in_rd_en, out_full = 0, out_wr_en;
   int checks = 0, errors = 0;

   gain_div #(.DATA_WIDTH(32)) dut (
      .clock(clock), .reset(reset), .gain(gain), .in_dout(in_dout), .in_empty(in_empty),
      .in_rd_en(in_rd_en), .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] din;
      logic [31:0] gain;
      logic [31:0] exp;
      int lat;
      int hold;
      string name;
   } vec_t;

   function automatic logic [31:0] ref_div(input logic [31:0] d, input logic [31:0] g);
      longint sd, dv;
      if (g == 0) return d[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      sd = longint'($signed(d));
      dv = longint'(g) * 16;
      return 32'(sd / dv);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clock) begin
      #2;
      if (in_rd_en && out_wr_en) begin
         errors++;
         $display("FAIL strobe_overlap: in_rd_en and out_wr_en both high at %0t", $time);
      end
   end

   task automatic do_one(input vec_t v);
      int n;
      @(negedge clock);
      in_dout = v.din; gain = v.gain; in_empty = 0; out_full = (v.hold > 0);
      #1 chk({v.name, " rd_en"}, 32'(in_rd_en), 1);
      @(negedge clock);
      in_empty = (v.hold == 0); gain = $urandom; in_dout = $urandom;
      #1 n = 1;
      while (n < 100 && (v.hold > 0 ? n < v.lat : !out_wr_en)) begin
         @(negedge clock); #1 n++;
      end
      chk({v.name, " latency"}, 32'(n), 32'(v.lat));
      for (int i = 0; i < v.hold; i++) begin
         chk({v.name, " stall wr_en"}, 32'(out_wr_en), 0);
         chk({v.name, " stall rd_en"}, 32'(in_rd_en), 0);
         chk({v.name, " stall dout"}, out_din, v.exp);
         @(negedge clock); #1;
      end
      out_full = 0; in_empty = 1;
      #1 chk({v.name, " wr_en"}, 32'(out_wr_en), 1);
      chk({v.name, " dout"}, out_din, v.exp);
      @(negedge clock); #1 chk({v.name, " single write"}, 32'(out_wr_en), 0);
   endtask

   vec_t tbl[$];
   logic [31:0] src[$], exq[$];
   int got, cyc;

   initial begin
      tbl = '{
         '{32'd1600,        32'd10,          32'd10,          33, 0, "basic"},
         '{-32'sd1601,      32'd10,          32'hFFFF_FFF6,   33, 0, "neg_trunc"},
         '{-32'sd159,       32'd10,          32'd0,           33, 0, "neg_to_zero"},
         '{32'h8000_0000,   32'd1,           32'hF800_0000,   33, 0, "min_int"},
         '{32'h7FFF_FFFF,   32'hFFFF_FFFF,   32'd0,           33, 0, "max_gain"},
         '{32'd5,           32'd0,           32'h7FFF_FFFF,   1,  0, "div0_pos"},
         '{-32'sd5,         32'd0,           32'h8000_0000,   1,  0, "div0_neg"},
         '{32'd5904,        32'd3,           32'd123,         33, 10, "round_trip_stall"}
      };
      in_empty = 0;
      #12;
      chk("reset rd_en", 32'(in_rd_en), 0);
      chk("reset wr_en", 32'(out_wr_en), 0);
      chk("reset dout", out_din, 0);
      in_empty = 1;
      @(negedge clock) reset = 0;
      foreach (tbl[i]) do_one(tbl[i]);

      @(negedge clock);
      in_dout = 32'd1600; gain = 32'd10; in_empty = 0;
      @(negedge clock); in_empty = 1;
      repeat (15) @(negedge clock);
      reset = 1; in_dout = -32'sd3200; gain = 32'd20; in_empty = 0;
      #1 chk("mid reset wr_en", 32'(out_wr_en), 0);
      chk("mid reset rd_en", 32'(in_rd_en), 0);
      repeat (2) @(negedge clock);
      chk("mid reset dout", out_din, 0);
      reset = 0; in_empty = 1;
      do_one('{-32'sd3200, 32'd20, 32'hFFFF_FFF6, 33, 0, "after_reset"});

      for (int i = 0; i < 100; i++) begin
         src.push_back($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 200000) - 100000);
      end
      got = 0; cyc = 0;
      while (got < 100 && cyc < 20000) begin
         @(negedge clock);
         cyc++;
         in_empty = src.size() == 0 || $urandom_range(0, 3) == 0;
         in_dout = src.size() ? src[0] : $urandom;
         gain = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(1, 60);
         out_full = $urandom_range(0, 2) == 0;
         #1;
         if (in_rd_en) begin
            exq.push_back(ref_div(in_dout, gain));
            void'(src.pop_front());
         end
         if (out_wr_en) begin
            if (exq.size() == 0) chk("random unexpected write", out_din, 32'hXXXX_XXXX);
            else chk($sformatf("random #%0d", got), out_din, exq.pop_front());
            got++;
         end
      end
      chk("random output count", 32'(got), 100);
      in_empty = 1; out_full = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
